branch_predictor_table: RTL



---
 rtl/branch_predictor_table.sv | 127 ++++++++++++
 1 files changed

// File: rtl/branch_predictor_table.sv
// Table of saturating direction counters indexed by PC (optionally gshare).
// A sequential sweep initialises every entry after reset.
module branch_predictor_table #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                request,
    input  logic [PC_WIDTH-1:0] req_pc,
    output logic                prediction,
    output logic                pred_valid,
    input  logic                result,
    input  logic [PC_WIDTH-1:0] res_pc,
    input  logic                taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int HW      = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam logic [CTR_BITS-1:0]   CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0]   CTR_WNT = CTR_MAX >> 1;
    localparam logic [INDEX_BITS-1:0] LAST    = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [INDEX_BITS-1:0] r_ptr;
    logic [HW-1:0]         r_hist;
    logic [CTR_BITS-1:0]   r_table [ENTRIES];
    logic                  r_pred;
    logic                  r_pred_valid;

    logic                  w_run;
    logic [INDEX_BITS-1:0] w_hist_ext;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [INDEX_BITS-1:0] w_res_idx;
    logic [CTR_BITS-1:0]   w_res_ctr;
    logic [CTR_BITS-1:0]   w_res_new;
    logic [HW:0]           w_hist_sh;
    logic                  w_unused_pc;

    assign w_run       = (r_state == ST_RUN);
    assign ready       = w_run;
    assign prediction  = r_pred;
    assign pred_valid  = r_pred_valid;
    assign w_hist_sh   = {r_hist, taken};
    assign w_unused_pc = ^{req_pc, res_pc};

    // Zero-extend history to index width (stays zero in bimodal mode)
    always_comb begin
        w_hist_ext         = '0;
        w_hist_ext[HW-1:0] = r_hist;
    end

    assign w_req_idx = req_pc[INDEX_BITS+1:2] ^ w_hist_ext;
    assign w_res_idx = res_pc[INDEX_BITS+1:2] ^ w_hist_ext;

    // Saturating increment/decrement of the counter being resolved
    always_comb begin
        w_res_ctr = r_table[w_res_idx];
        w_res_new = w_res_ctr;
        if (taken && (w_res_ctr != CTR_MAX)) begin
            w_res_new = w_res_ctr + 1'b1;
        end else if (!taken && (w_res_ctr != '0)) begin
            w_res_new = w_res_ctr - 1'b1;
        end
    end

    // Next-state: leave INIT once the last entry has been written
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_INIT: if (r_ptr == LAST) w_next = ST_RUN;
            ST_RUN:  w_next = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_next;
    end

    // Sweep pointer advances only while initialising
    always_ff @(posedge clk) begin
        if (reset)                   r_ptr <= '0;
        else if (r_state == ST_INIT) r_ptr <= r_ptr + 1'b1;
    end

    // Counter storage: sweep writes in INIT, resolved updates in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_table[r_ptr] <= CTR_WNT;
            end else if (result) begin
                r_table[w_res_idx] <= w_res_new;
            end
        end
    end

    // Global history shifts in each resolved direction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
        end else if (w_run && result && (HIST_BITS > 0)) begin
            r_hist <= w_hist_sh[HW-1:0];
        end
    end

    // Registered prediction reads the pre-update counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred       <= 1'b0;
            r_pred_valid <= 1'b0;
        end else begin
            r_pred_valid <= w_run && request;
            if (w_run && request) begin
                r_pred <= r_table[w_req_idx][CTR_BITS-1];
            end
        end
    end

endmodule
